// File: rtl/rs_enc_block_sequencer.sv
// rs_enc_block_sequencer: frames an unframed symbol stream into K-symbol RS messages (zero-padding after idle timeout), passes codewords through and checks their framing
module rs_enc_block_sequencer #(
  parameter int m = 8,
  parameter int nblk = 255,
  parameter int check = 16,
  parameter int timeout = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [m-1:0]                 in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         enc_ena,
  output logic                         enc_val,
  output logic                         enc_sop,
  output logic                         enc_eop,
  output logic [m-1:0]                 enc_data,
  input  logic                         enc_out_val,
  input  logic                         enc_out_sop,
  input  logic                         enc_out_eop,
  input  logic [m-1:0]                 enc_out_data,
  output logic                         enc_out_ena,
  output logic [m-1:0]                 out_data,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  input  logic                         out_ready,
  output logic [$clog2(nblk+1)-1:0]    last_pad,
  output logic [15:0]                  blk_count,
  output logic                         frame_err
);
  localparam int K = nblk - check;
  localparam int CW = $clog2(nblk + 1);
  typedef enum logic [1:0] {IDLE, DATA, PAD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, pad_cnt, ocnt;
  logic [15:0] idle;
  logic pad, xfer, last, timeout_hit, oxfer;
  always_comb begin
    pad = state == PAD;
    enc_val = !reset && (pad || in_valid);
    enc_data = pad ? '0 : in_data;
    in_ready = !reset && !pad && enc_ena;
    xfer = enc_val && enc_ena;
    last = cnt == CW'(K - 1);
    enc_sop = enc_val && cnt == '0;
    enc_eop = enc_val && last;
    timeout_hit = timeout != 0 && idle == 16'(timeout);
    state_n = xfer ? (last ? IDLE : (pad ? PAD : DATA)) :
              (state == DATA && timeout_hit) ? PAD : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idle <= '0;
      pad_cnt <= '0;
      last_pad <= '0;
    end else begin
      state <= state_n;
      if (xfer) cnt <= last ? '0 : cnt + CW'(1);
      idle <= (xfer || state != DATA) ? '0 : idle + 16'd1;
      if (xfer && last) begin
        last_pad <= pad_cnt + CW'(pad);
        pad_cnt <= '0;
      end else if (xfer && pad) begin
        pad_cnt <= pad_cnt + CW'(1);
      end
    end
  end
  assign out_data = enc_out_data;
  assign out_valid = enc_out_val;
  assign out_sop = enc_out_sop;
  assign out_eop = enc_out_eop;
  assign enc_out_ena = out_ready;
  assign oxfer = enc_out_val && out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      ocnt <= '0;
      blk_count <= '0;
      frame_err <= 1'b0;
    end else if (oxfer) begin
      if (enc_out_sop != (ocnt == '0) || enc_out_eop != (ocnt == CW'(nblk - 1))) frame_err <= 1'b1;
      ocnt <= (enc_out_eop || ocnt == CW'(nblk - 1)) ? '0 : ocnt + CW'(1);
      if (enc_out_eop) blk_count <= blk_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_rs_enc_block_sequencer.sv
// tb_rs_enc_block_sequencer: randomized self-checking bench with a queue-based encoder and message model
module tb_rs_enc_block_sequencer;
  logic clk = 0;
  logic reset = 1;
  logic [3:0] in_data = 0;
  logic in_valid = 0;
  logic in_ready;
  logic enc_ena = 1;
  logic enc_val, enc_sop, enc_eop;
  logic [3:0] enc_data;
  logic enc_out_val = 0, enc_out_sop = 0, enc_out_eop = 0;
  logic [3:0] enc_out_data = 0;
  logic enc_out_ena;
  logic [3:0] out_data;
  logic out_valid, out_sop, out_eop;
  logic out_ready = 1;
  logic [3:0] last_pad;
  logic [15:0] blk_count;
  logic frame_err;
  rs_enc_block_sequencer #(.m(4), .nblk(15), .check(4), .timeout(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .enc_ena(enc_ena), .enc_val(enc_val), .enc_sop(enc_sop), .enc_eop(enc_eop), .enc_data(enc_data),
    .enc_out_val(enc_out_val), .enc_out_sop(enc_out_sop), .enc_out_eop(enc_out_eop),
    .enc_out_data(enc_out_data), .enc_out_ena(enc_out_ena), .out_data(out_data),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready),
    .last_pad(last_pad), .blk_count(blk_count), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [3:0] d; bit s; bit e;} sym_t;
  sym_t outq[$];
  logic [3:0] msg[$];
  logic [3:0] od[$];
  bit os[$], oe[$], ordy[$];
  int ocyc[$];
  int cyc = 0, eops = 0, ref_blocks = 0, total = 0, bad = 0;
  bit bp = 0, rnd_out = 0, bad_eop = 0;
  bit in_x, in_e, out_x, rst_s;
  logic [3:0] in_d, par;
  always @(negedge clk) begin
    cyc++;
    rst_s = reset;
    in_x = enc_val && enc_ena;
    in_d = enc_data;
    in_e = enc_eop;
    out_x = enc_out_val && out_ready;
    if (in_x) begin
      od.push_back(enc_data);
      os.push_back(enc_sop);
      oe.push_back(enc_eop);
      ordy.push_back(in_ready);
      ocyc.push_back(cyc);
      if (enc_eop) eops++;
    end
    if (out_x) begin
      total++;
      if ({out_valid, out_data, out_sop, out_eop} !== {1'b1, outq[0].d, outq[0].s, outq[0].e}) begin
        bad++;
        $display("FAIL passthru got=%b_%h_%b%b exp=1_%h_%b%b", out_valid, out_data, out_sop, out_eop, outq[0].d, outq[0].s, outq[0].e);
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rst_s) begin
      msg.delete();
      outq.delete();
      ref_blocks = 0;
    end else begin
      if (out_x) begin
        if (outq[0].e) ref_blocks++;
        void'(outq.pop_front());
      end
      if (in_x) begin
        msg.push_back(in_d);
        if (in_e) begin
          par = 0;
          for (int i = 0; i < 11; i++) begin
            outq.push_back('{msg[i], i == 0, 1'b0});
            par ^= msg[i];
          end
          for (int j = 0; j < 4; j++) outq.push_back('{par ^ 4'(j), 1'b0, bad_eop ? (j == 1) : (j == 3)});
          msg.delete();
        end
      end
    end
    enc_ena = bp ? ~enc_ena : 1'b1;
    out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
    enc_out_val = outq.size() > 0;
    enc_out_data = outq.size() > 0 ? outq[0].d : 4'h0;
    enc_out_sop = outq.size() > 0 ? outq[0].s : 1'b0;
    enc_out_eop = outq.size() > 0 ? outq[0].e : 1'b0;
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic clear_obs;
    od.delete();
    os.delete();
    oe.delete();
    ordy.delete();
    ocyc.delete();
    eops = 0;
  endtask
  task automatic send(input logic [3:0] d);
    bit ok = 0;
    in_valid = 1;
    in_data = d;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge clk);
      if (bp) begin
        total++;
        if (in_ready !== enc_ena) begin
          bad++;
          $display("FAIL bp_ready got=%b exp=%b", in_ready, enc_ena);
        end
      end
      ok = in_ready;
      tick();
    end
    in_valid = 0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout sym=%h not accepted", d);
    end
  endtask
  task automatic wait_drain(input int need);
    bit done = 0;
    for (int w = 0; w < 1500 && !done; w++) begin
      if (eops >= need && outq.size() == 0) done = 1;
      else tick();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout eops=%0d need=%0d", eops, need);
    end
  endtask
  task automatic test_reset;
    in_valid = 1;
    in_data = 5;
    @(negedge clk);
    total++;
    if ({enc_val, in_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hs got=%b%b exp=00", enc_val, in_ready);
    end
    tick();
    reset = 0;
    in_valid = 0;
    @(negedge clk);
    total++;
    if ({last_pad, blk_count, frame_err, enc_val} !== 22'd0) begin
      bad++;
      $display("FAIL reset_vals got=%h/%h/%b/%b exp=0/0/0/0", last_pad, blk_count, frame_err, enc_val);
    end
    tick();
  endtask
  task automatic test_full_message;
    clear_obs();
    for (int i = 1; i <= 11; i++) send(4'(i));
    wait_drain(1);
    @(negedge clk);
    total++;
    if (od.size() != 11) begin
      bad++;
      $display("FAIL full_len got=%0d exp=11", od.size());
    end
    for (int i = 0; i < 11 && i < od.size(); i++) begin
      total++;
      if ({od[i], os[i], oe[i]} !== {4'(i + 1), i == 0, i == 10}) begin
        bad++;
        $display("FAIL full_sym[%0d] got=%h%b%b exp=%h%b%b", i, od[i], os[i], oe[i], 4'(i + 1), i == 0, i == 10);
      end
    end
    total++;
    if ({last_pad, blk_count, frame_err} !== {4'd0, 16'd1, 1'b0}) begin
      bad++;
      $display("FAIL full_status got=%0d/%0d/%b exp=0/1/0", last_pad, blk_count, frame_err);
    end
    tick();
  endtask
  task automatic test_back_to_back;
    logic [3:0] s[11];
    clear_obs();
    bp = 1;
    for (int i = 0; i < 11; i++) begin
      s[i] = 4'($urandom_range(0, 15));
      send(s[i]);
    end
    bp = 0;
    wait_drain(1);
    @(negedge clk);
    total++;
    if (od.size() != 11) begin
      bad++;
      $display("FAIL bp_len got=%0d exp=11", od.size());
    end
    for (int i = 0; i < 11 && i < od.size(); i++) begin
      total++;
      if ({od[i], os[i], oe[i]} !== {s[i], i == 0, i == 10}) begin
        bad++;
        $display("FAIL bp_sym[%0d] got=%h%b%b exp=%h%b%b", i, od[i], os[i], oe[i], s[i], i == 0, i == 10);
      end
    end
    total++;
    if (blk_count !== 16'd2) begin
      bad++;
      $display("FAIL bp_blk got=%0d exp=2", blk_count);
    end
    tick();
  endtask
  task automatic test_timeout_pad;
    logic [3:0] s[4];
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      s[i] = 4'($urandom_range(1, 15));
      send(s[i]);
    end
    wait_drain(1);
    @(negedge clk);
    total++;
    if (od.size() != 11) begin
      bad++;
      $display("FAIL pad_len got=%0d exp=11", od.size());
    end
    for (int i = 0; i < 11 && i < od.size(); i++) begin
      total++;
      if ({od[i], os[i], oe[i], ordy[i]} !== {i < 4 ? s[i] : 4'h0, i == 0, i == 10, i < 4}) begin
        bad++;
        $display("FAIL pad_sym[%0d] got=%h%b%b rdy=%b exp=%h%b%b rdy=%b", i, od[i], os[i], oe[i], ordy[i], i < 4 ? s[i] : 4'h0, i == 0, i == 10, i < 4);
      end
    end
    if (od.size() > 4) begin
      total++;
      if (ocyc[4] - ocyc[3] != 10) begin
        bad++;
        $display("FAIL pad_start gap got=%0d exp=10", ocyc[4] - ocyc[3]);
      end
    end
    total++;
    if ({last_pad, blk_count} !== {4'd7, 16'd3}) begin
      bad++;
      $display("FAIL pad_status got=%0d/%0d exp=7/3", last_pad, blk_count);
    end
    tick();
  endtask
  task automatic test_race;
    logic [3:0] s[5];
    clear_obs();
    for (int i = 0; i < 5; i++) s[i] = 4'($urandom_range(1, 15));
    for (int i = 0; i < 4; i++) send(s[i]);
    repeat (8) tick();
    send(s[4]);
    wait_drain(1);
    @(negedge clk);
    total++;
    if (od.size() != 11) begin
      bad++;
      $display("FAIL race_len got=%0d exp=11", od.size());
    end
    for (int i = 0; i < 11 && i < od.size(); i++) begin
      total++;
      if ({od[i], os[i], oe[i]} !== {i < 5 ? s[i] : 4'h0, i == 0, i == 10}) begin
        bad++;
        $display("FAIL race_sym[%0d] got=%h%b%b exp=%h%b%b", i, od[i], os[i], oe[i], i < 5 ? s[i] : 4'h0, i == 0, i == 10);
      end
    end
    if (od.size() > 4) begin
      total++;
      if (ocyc[4] - ocyc[3] != 9) begin
        bad++;
        $display("FAIL race_gap got=%0d exp=9", ocyc[4] - ocyc[3]);
      end
    end
    total++;
    if ({last_pad, blk_count} !== {4'd6, 16'd4}) begin
      bad++;
      $display("FAIL race_status got=%0d/%0d exp=6/4", last_pad, blk_count);
    end
    tick();
  endtask
  task automatic test_random;
    logic [3:0] s[33];
    clear_obs();
    rnd_out = 1;
    for (int i = 0; i < 33; i++) begin
      s[i] = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 7)) tick();
      send(s[i]);
    end
    wait_drain(3);
    rnd_out = 0;
    @(negedge clk);
    total++;
    if (od.size() != 33) begin
      bad++;
      $display("FAIL rnd_len got=%0d exp=33", od.size());
    end
    for (int i = 0; i < 33 && i < od.size(); i++) begin
      total++;
      if ({od[i], os[i], oe[i]} !== {s[i], i % 11 == 0, i % 11 == 10}) begin
        bad++;
        $display("FAIL rnd_sym[%0d] got=%h%b%b exp=%h%b%b", i, od[i], os[i], oe[i], s[i], i % 11 == 0, i % 11 == 10);
      end
    end
    total++;
    if ({last_pad, blk_count, frame_err} !== {4'd0, 16'(ref_blocks), 1'b0}) begin
      bad++;
      $display("FAIL rnd_status got=%0d/%0d/%b exp=0/%0d/0", last_pad, blk_count, frame_err, ref_blocks);
    end
    tick();
  endtask
  task automatic test_frame_err;
    clear_obs();
    bad_eop = 1;
    for (int i = 0; i < 11; i++) send(4'($urandom_range(0, 15)));
    wait_drain(1);
    @(negedge clk);
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL ferr_set got=%b exp=1", frame_err);
    end
    tick();
    bad_eop = 0;
    clear_obs();
    for (int i = 0; i < 11; i++) send(4'($urandom_range(0, 15)));
    wait_drain(1);
    @(negedge clk);
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL ferr_sticky got=%b exp=1", frame_err);
    end
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    total++;
    if ({frame_err, blk_count} !== 17'd0) begin
      bad++;
      $display("FAIL ferr_clear got=%b/%0d exp=0/0", frame_err, blk_count);
    end
    tick();
  endtask
  task automatic test_reset_mid;
    logic [3:0] s[11];
    clear_obs();
    for (int i = 0; i < 6; i++) send(4'($urandom_range(0, 15)));
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    total++;
    if ({blk_count, last_pad} !== 20'd0) begin
      bad++;
      $display("FAIL mid_reset got=%0d/%0d exp=0/0", blk_count, last_pad);
    end
    tick();
    clear_obs();
    for (int i = 0; i < 11; i++) begin
      s[i] = 4'($urandom_range(0, 15));
      send(s[i]);
    end
    wait_drain(1);
    @(negedge clk);
    total++;
    if (od.size() != 11) begin
      bad++;
      $display("FAIL mid_len got=%0d exp=11", od.size());
    end
    for (int i = 0; i < 11 && i < od.size(); i++) begin
      total++;
      if ({od[i], os[i], oe[i]} !== {s[i], i == 0, i == 10}) begin
        bad++;
        $display("FAIL mid_sym[%0d] got=%h%b%b exp=%h%b%b", i, od[i], os[i], oe[i], s[i], i == 0, i == 10);
      end
    end
    total++;
    if ({blk_count, frame_err} !== {16'd1, 1'b0}) begin
      bad++;
      $display("FAIL mid_status got=%0d/%b exp=1/0", blk_count, frame_err);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_full_message();
    test_back_to_back();
    test_timeout_pad();
    test_race();
    test_random();
    test_frame_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
